hex_scan_mux: RTL and testbench
===============================

Name: hex_scan_mux

Overview:
- Downstream consumer of the 7-segment PIO output.
- Captures 7-bit segment patterns into per-digit registers.
- Time-multiplexes the patterns onto a shared common-anode/cathode display: one segment bus plus one enable line per digit.
- Provides inter-digit blanking (anti-ghosting), per-digit blink, and a frame tick for software or verification sync.

Parameters:
- NUM_DIGITS, 4: digits scanned, range 2..8.
- SEL_W, 2: width of digit_sel; must be at least ceil(log2(NUM_DIGITS)).
- SCAN_DIV, 50000: clocks per digit slot, including blanking; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 500: clocks at the start of each slot with all digits off.
- BLINK_FRAMES, 128: full scan frames per blink half-period.
- ACTIVE_LOW, 1: 1 means seg_out and dig_en are inverted at the pins (segment on = 0).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- seg_in  in  7  segment pattern from the PIO, bit0 = segment a ... bit6 = segment g; 1 = lit, before polarity.
- load  in  1  one-cycle strobe; captures seg_in into digit digit_sel.
- digit_sel  in  SEL_W  target digit for load.
- blink_en  in  NUM_DIGITS  per-digit blink enable, level-sensitive.
- enable  in  1  scan enable; low forces display dark.
- seg_out  out  7  registered segment drive, polarity per ACTIVE_LOW.
- dig_en  out  NUM_DIGITS  registered one-hot digit enable, polarity per ACTIVE_LOW.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Reset (async assert, sync release):
  - All pattern registers = 0.
  - Slot counter = 0, digit index = 0, frame counter = 0, blink phase = 0.
  - State = IDLE.
  - seg_out = all-off (7'h7F if ACTIVE_LOW else 7'h00); dig_en = all-off; frame_tick = 0.
- Load:
  - On a clk edge with load=1 and digit_sel < NUM_DIGITS, pattern[digit_sel] <= seg_in.
  - digit_sel >= NUM_DIGITS: ignored, no register changes.
  - Load is accepted in every state, including IDLE.
- State machine:
  - IDLE: outputs off, counters held at 0. Exits to BLANK with digit 0 on the first cycle enable=1.
  - BLANK: dig_en all-off, seg_out all-off. Slot counter counts 0..BLANK_CYCLES-1, then goes to DRIVE.
  - DRIVE: dig_en selects the current digit; seg_out = pattern[digit], or all-off if blink_en[digit]=1 and blink phase=1. On slot counter = SCAN_DIV-1: slot counter -> 0, digit increments modulo NUM_DIGITS, go to BLANK.
  - enable=0 in any state: next cycle IDLE, all counters reset to 0, blink phase cleared.
- Timing:
  - Outputs are registered and follow state/counter values with 1 cycle latency.
  - A load to the digit currently in DRIVE shows on seg_out 2 cycles after the load edge (register write, then output register).
  - A load to any other digit shows in that digit's next DRIVE slot.
- Frame and blink:
  - frame_tick is high for exactly 1 cycle, aligned with the first BLANK cycle of digit 0 after digit NUM_DIGITS-1 completes.
  - The first entry from IDLE does not generate frame_tick.
  - Frame counter counts frame_ticks 0..BLINK_FRAMES-1; on wrap it toggles blink phase.
- Boundary cases:
  - Simultaneous load and slot wrap: both take effect, with no lost write.
  - blink_en changes mid-slot: take effect on the next cycle's output.
  - Reset mid-DRIVE: outputs go dark immediately (async), not at the next edge.
- Polarity: ACTIVE_LOW inverts only the final output registers' values. Internal logic is always active-high.

Test Plan:
- Params NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2, ACTIVE_LOW=1 unless noted.
- Reset/idle: hold reset 3 cycles with enable=1, then release -> seg_out=7'h7F and dig_en=4'hF during reset; the first DRIVE cycle for digit 0 has dig_en=4'hE.
- Scan order: load 7'h3F/06/5B/4F into digits 0..3 -> seg_out=7'h40, 79, 24, 30 (inverted) in successive slots. Each slot = 2 dark cycles + 6 driven cycles. frame_tick is a single pulse every 32 cycles.
- Live update: load 7'h7F into digit 1 while digit 1 is in DRIVE -> seg_out=7'h00 exactly 2 cycles after the load edge. A load with digit_sel=2'd3 to a 3-digit instance (NUM_DIGITS=3) changes nothing.
- Blink: blink_en=4'b0100 -> digit 2 is dark in frames 2-3 and 6-7 and lit in frames 0-1 and 4-5; other digits are unaffected.
- Enable drop: deassert enable mid-DRIVE of digit 3 -> outputs all-off the next cycle. Reassert -> restart at digit 0 BLANK with no frame_tick, and pattern registers retained.
- Async reset mid-DRIVE: assert reset between clk edges -> seg_out=7'h7F and dig_en=4'hF before the next edge; patterns read 0 after release.

Source files
------------

// File: rtl/hex_scan_mux.sv
// hex_scan_mux: time-multiplexed 7-segment display driver with
// inter-digit blanking, per-digit blink and a frame tick.
module hex_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SEL_W        = 2,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 128,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic                  load,
  input  logic [SEL_W-1:0]      digit_sel,
  input  logic [NUM_DIGITS-1:0] blink_en,
  input  logic                  enable,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV + 1);
  localparam int FR_W  = $clog2(BLINK_FRAMES + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] DIG_LAST   = SEL_W'(NUM_DIGITS - 1);
  localparam logic [FR_W-1:0]  FR_LAST    = FR_W'(BLINK_FRAMES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{ACTIVE_LOW}};

  logic [NUM_DIGITS-1:0][6:0] pat_q;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] slot_q, slot_d;
  logic [SEL_W-1:0] digit_q, digit_d;
  logic [FR_W-1:0]  frame_q, frame_d;
  logic             blink_q, blink_d;
  logic             tick_q, tick_d;

  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic [6:0]            cur_pat;
  logic                  cur_blink;
  logic [NUM_DIGITS-1:0] cur_dig;
  logic                  drive;

  // Pattern registers: out-of-range digit_sel matches no digit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (load && digit_sel == SEL_W'(i)) begin
          pat_q[i] <= seg_in;
        end
      end
    end
  end

  // Scan sequencer: slot counter, digit index, frame and blink phase
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    digit_d = digit_q;
    frame_d = frame_q;
    blink_d = blink_q;
    tick_d  = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      slot_d  = '0;
      digit_d = '0;
      frame_d = '0;
      blink_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          slot_d  = '0;
          digit_d = '0;
        end
        S_BLANK: begin
          slot_d = slot_q + 1'b1;
          if (slot_q == BLANK_LAST) begin
            state_d = S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (slot_q == SLOT_LAST) begin
            slot_d  = '0;
            state_d = S_BLANK;
            if (digit_q == DIG_LAST) begin
              digit_d = '0;
              tick_d  = 1'b1;
              if (frame_q == FR_LAST) begin
                frame_d = '0;
                blink_d = ~blink_q;
              end else begin
                frame_d = frame_q + 1'b1;
              end
            end else begin
              digit_d = digit_q + 1'b1;
            end
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          slot_d  = '0;
          digit_d = '0;
        end
      endcase
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      digit_q <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      digit_q <= digit_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
    end
  end

  // Select current digit's pattern, blink bit and one-hot enable
  always_comb begin
    cur_pat   = '0;
    cur_blink = 1'b0;
    cur_dig   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_q == SEL_W'(i)) begin
        cur_pat    = pat_q[i];
        cur_blink  = blink_en[i];
        cur_dig[i] = 1'b1;
      end
    end
    drive = enable && (state_q == S_DRIVE);
    seg_d = (drive && !(cur_blink && blink_q)) ? cur_pat : '0;
    dig_d = drive ? cur_dig : '0;
  end

  // Output registers; polarity applied only here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_OFF;
      dig_q <= DIG_OFF;
    end else begin
      seg_q <= seg_d ^ SEG_OFF;
      dig_q <= dig_d ^ DIG_OFF;
    end
  end

  assign seg_out    = seg_q;
  assign dig_en     = dig_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_hex_scan_mux.sv
// tb_hex_scan_mux: directed checks of scan order, blink, live
// update, enable drop, async reset and out-of-range load.
module tb_hex_scan_mux;

  logic       clk;
  logic       reset;
  logic [6:0] seg_in;
  logic       load;
  logic [1:0] sel;
  logic [3:0] blink;
  logic       en;
  logic [6:0] seg_o;
  logic [3:0] dig_o;
  logic       ft;

  logic [6:0] seg_in3;
  logic       load3;
  logic [1:0] sel3;
  logic [2:0] blink3;
  logic       en3;
  logic [6:0] seg_o3;
  logic [2:0] dig_o3;
  logic       ft3;

  int n_run;
  int n_fail;

  logic [6:0] pat     [4];
  logic [6:0] exp_seg [4];
  logic [3:0] exp_dig [4];

  int j, d, s, f, nt, first_k;

  hex_scan_mux #(
    .NUM_DIGITS(4), .SEL_W(2), .SCAN_DIV(8),
    .BLANK_CYCLES(2), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)
  ) u4 (
    .clk(clk), .reset(reset), .seg_in(seg_in), .load(load),
    .digit_sel(sel), .blink_en(blink), .enable(en),
    .seg_out(seg_o), .dig_en(dig_o), .frame_tick(ft)
  );

  hex_scan_mux #(
    .NUM_DIGITS(3), .SEL_W(2), .SCAN_DIV(8),
    .BLANK_CYCLES(2), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)
  ) u3 (
    .clk(clk), .reset(reset), .seg_in(seg_in3), .load(load3),
    .digit_sel(sel3), .blink_en(blink3), .enable(en3),
    .seg_out(seg_o3), .dig_en(dig_o3), .frame_tick(ft3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    pat[0] = 7'h3F; pat[1] = 7'h06;
    pat[2] = 7'h5B; pat[3] = 7'h4F;
    exp_seg[0] = 7'h40; exp_seg[1] = 7'h79;
    exp_seg[2] = 7'h24; exp_seg[3] = 7'h30;
    exp_dig[0] = 4'hE; exp_dig[1] = 4'hD;
    exp_dig[2] = 4'hB; exp_dig[3] = 4'h7;

    reset = 1'b1; en = 1'b1; load = 1'b0;
    seg_in = '0; sel = '0; blink = '0;
    seg_in3 = '0; load3 = 1'b0; sel3 = '0;
    blink3 = '0; en3 = 1'b0;

    // reset held 3 cycles with enable high
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_seg", seg_o, 7'h7F);
      check("rst_dig", dig_o, 4'hF);
      check("rst_tick", ft, 1'b0);
    end
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("first_blank_dig", dig_o, 4'hF);
    tick();
    check("first_drive_dig", dig_o, 4'hE);
    check("first_drive_seg", seg_o, 7'h7F);

    // idle, load patterns, enable with digit 2 blinking
    en = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      seg_in = pat[i];
      sel = 2'(i);
      load = 1'b1;
      tick();
      check("idle_seg", seg_o, 7'h7F);
      check("idle_dig", dig_o, 4'hF);
    end
    load = 1'b0;
    blink = 4'b0100;
    en = 1'b1;
    nt = 0;
    first_k = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (ft) begin
        nt++;
        if (first_k == 0) first_k = k;
      end
      if (k >= 2) begin
        j = k - 2;
        d = (j / 8) % 4;
        s = j % 8;
        f = j / 32;
        if (s == 1) check("scan_blank_dig", dig_o, 4'hF);
        if (s == 2) begin
          check("scan_dig", dig_o, exp_dig[d]);
          if (d == 2 && (f % 4) >= 2)
            check("blink_dark", seg_o, 7'h7F);
          else
            check("scan_seg", seg_o, exp_seg[d]);
        end
      end
    end
    check("tick_count", nt, 7);
    check("tick_first", first_k, 33);

    // restart: live update and enable drop
    en = 1'b0;
    blink = '0;
    tick();
    en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 12) begin
        seg_in = 7'h7F;
        sel = 2'd1;
        load = 1'b1;
      end
      if (k == 13) begin
        load = 1'b0;
        check("live_old_seg", seg_o, 7'h79);
        check("live_old_dig", dig_o, 4'hD);
      end
      if (k == 14) check("live_new_seg", seg_o, 7'h00);
    end
    check("d3_drive_dig", dig_o, 4'h7);
    check("d3_drive_seg", seg_o, 7'h30);
    en = 1'b0;
    tick();
    check("endrop_seg", seg_o, 7'h7F);
    check("endrop_dig", dig_o, 4'hF);
    check("endrop_tick", ft, 1'b0);
    tick();
    en = 1'b1;
    nt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (ft) nt++;
      if (k == 4) begin
        check("reen_d0_seg", seg_o, 7'h40);
        check("reen_d0_dig", dig_o, 4'hE);
      end
    end
    check("reen_d1_seg", seg_o, 7'h00);
    check("reen_d1_dig", dig_o, 4'hD);
    check("reen_no_tick", nt, 0);

    // async reset mid-DRIVE of digit 1
    #3;
    reset = 1'b1;
    #1;
    check("arst_seg", seg_o, 7'h7F);
    check("arst_dig", dig_o, 4'hF);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) begin
        check("arst_p0_seg", seg_o, 7'h7F);
        check("arst_p0_dig", dig_o, 4'hE);
      end
    end
    check("arst_p1_seg", seg_o, 7'h7F);
    check("arst_p1_dig", dig_o, 4'hD);
    en = 1'b0;

    // 3-digit instance: digit_sel 3 must be ignored
    for (int i = 0; i < 4; i++) begin
      seg_in3 = (i == 3) ? 7'h7F : pat[i];
      sel3 = 2'(i);
      load3 = 1'b1;
      tick();
    end
    load3 = 1'b0;
    en3 = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      tick();
      if (k == 4) begin
        check("n3_d0_seg", seg_o3, 7'h40);
        check("n3_d0_dig", dig_o3, 3'b110);
      end
      if (k == 12) begin
        check("n3_d1_seg", seg_o3, 7'h79);
        check("n3_d1_dig", dig_o3, 3'b101);
      end
      if (k == 20) begin
        check("n3_d2_seg", seg_o3, 7'h24);
        check("n3_d2_dig", dig_o3, 3'b011);
      end
      if (k == 24) check("n3_tick_pre", ft3, 1'b0);
      if (k == 25) check("n3_tick", ft3, 1'b1);
    end
    check("n3_d0_again", seg_o3, 7'h40);
    en3 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
